// File: rtl/sprite_renderer.sv
// Single-sprite scanline renderer: fetches one 16-pixel ROM row during the
// horizontal blank before each sprite line, then shifts it out as gfx when the beam reaches sprite_x.
module sprite_renderer (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic [8:0] sprite_x,
    input  logic [8:0] sprite_y,
    input  logic [1:0] direction,
    input  logic       anim,
    output logic [1:0] rom_dir,
    output logic       rom_anim,
    output logic [3:0] rom_yofs,
    output logic [3:0] rom_xofs,
    input  logic       rom_bit,
    output logic       gfx,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_FETCH,
        S_WAIT_X,
        S_DRAW,
        S_WAIT_FETCH,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [3:0]  r_row;
    logic [3:0]  w_row_nx;
    logic [3:0]  r_col;
    logic [3:0]  w_col_nx;
    logic [15:0] r_buf;
    logic [15:0] w_buf_nx;
    logic [8:0]  r_x;
    logic [8:0]  r_y;
    logic [1:0]  r_dir;
    logic        r_anim;
    logic        r_gfx;
    logic [8:0]  w_next_line;
    logic        w_last_col;
    logic        w_last_row;

    // line_start marks the blank before the next line, so compare against vpos+1
    assign w_next_line = vpos + 9'd1;
    assign w_last_col  = (r_col == 4'd15);
    assign w_last_row  = (r_row == 4'd15);

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_buf_nx   = r_buf;
        if (frame_start) begin
            w_state_nx = S_WAIT_LINE;
            w_row_nx   = 4'd0;
            w_col_nx   = 4'd0;
        end else begin
            case (r_state)
                S_WAIT_LINE: begin
                    if (line_start && (w_next_line == r_y)) begin
                        w_state_nx = S_FETCH;
                        w_col_nx   = 4'd0;
                    end
                end
                S_FETCH: begin
                    w_buf_nx[4'd15 - r_col] = rom_bit;
                    if (w_last_col) begin
                        w_state_nx = S_WAIT_X;
                        w_col_nx   = 4'd0;
                    end else begin
                        w_col_nx = r_col + 4'd1;
                    end
                end
                S_WAIT_X: begin
                    if (hpos == r_x) begin
                        w_state_nx = S_DRAW;
                        w_col_nx   = 4'd0;
                    end else if (line_start) begin
                        // x never reached on this line: count the row as drawn
                        w_col_nx = 4'd0;
                        if (w_last_row) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_FETCH;
                            w_row_nx   = r_row + 4'd1;
                        end
                    end
                end
                S_DRAW: begin
                    if (w_last_col) begin
                        w_col_nx = 4'd0;
                        if (w_last_row) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_WAIT_FETCH;
                            w_row_nx   = r_row + 4'd1;
                        end
                    end else begin
                        w_col_nx = r_col + 4'd1;
                    end
                end
                S_WAIT_FETCH: begin
                    if (line_start) begin
                        w_state_nx = S_FETCH;
                        w_col_nx   = 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= 4'd0;
            r_col   <= 4'd0;
            r_buf   <= 16'd0;
            r_x     <= 9'd0;
            r_y     <= 9'd0;
            r_dir   <= 2'd0;
            r_anim  <= 1'b0;
            r_gfx   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            r_buf   <= w_buf_nx;
            if (frame_start) begin
                r_x    <= sprite_x;
                r_y    <= sprite_y;
                r_dir  <= direction;
                r_anim <= anim;
            end
            // Load the pixel for the column about to be shown so gfx lines up with hpos = x+1+k
            r_gfx <= (w_state_nx == S_DRAW) ? r_buf[4'd15 - w_col_nx] : 1'b0;
        end
    end

    assign rom_dir  = r_dir;
    assign rom_anim = r_anim;
    assign rom_yofs = r_row;
    assign rom_xofs = (r_state == S_FETCH) ? r_col : 4'd0;
    assign gfx      = r_gfx;
    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: drives a small raster (136 x 70) and compares every
// scanline of gfx with a picture computed directly from sprite position and ROM contents.
module tb_sprite_renderer;

    localparam int H    = 136;
    localparam int LS_H = 128;
    localparam int V    = 70;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       frame_start;
    logic       line_start;
    logic [8:0] sprite_x;
    logic [8:0] sprite_y;
    logic [1:0] direction;
    logic       anim;
    logic [1:0] rom_dir;
    logic       rom_anim;
    logic [3:0] rom_yofs;
    logic [3:0] rom_xofs;
    logic       rom_bit;
    logic       gfx;
    logic       busy;

    logic [15:0]  rom_mem  [0:127];
    logic [159:0] line_obs [0:V-1];
    logic [159:0] pat_line;
    int n_tests = 0;
    int n_fail  = 0;

    sprite_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .frame_start (frame_start),
        .line_start  (line_start),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .direction   (direction),
        .anim        (anim),
        .rom_dir     (rom_dir),
        .rom_anim    (rom_anim),
        .rom_yofs    (rom_yofs),
        .rom_xofs    (rom_xofs),
        .rom_bit     (rom_bit),
        .gfx         (gfx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Column 0 of a ROM row is its MSB
    assign rom_bit = rom_mem[{rom_dir, rom_anim, rom_yofs}][4'd15 - rom_xofs];

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_line(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected pixel at beam (v,h): sprite row r sits on line sy+r, column k at hpos sx+1+k
    function automatic logic exp_pix(input int sx, input int sy, input int d, input int a,
                                     input int v, input int h);
        int r;
        int k;
        logic [15:0] w;
        if (sx < 10 || sx + 16 >= LS_H) return 1'b0;
        r = v - sy;
        k = h - sx - 1;
        if (r < 0 || r > 15 || k < 0 || k > 15) return 1'b0;
        w = rom_mem[d * 32 + a * 16 + r];
        return w[15 - k];
    endfunction

    // mode 0: plain frame, 1: frame_start+line_start at (iv,ih) with new sprite, 2: reset pulse at (iv,ih)
    task automatic run_frame(input int sx, input int sy, input int d, input int a,
                             input bit do_fs, input int nlines, input int mode,
                             input int iv, input int ih,
                             input int nx, input int ny, input int nd, input int na);
        int cx;
        int cy;
        int cd;
        int ca;
        bit active;
        bit fs_seen;
        logic [159:0] obs;
        logic [159:0] expv;
        cx = sx; cy = sy; cd = d; ca = a;
        active = 1'b0;
        fs_seen = 1'b0;
        for (int v = 0; v < nlines; v++) begin
            obs  = '0;
            expv = '0;
            for (int h = 0; h < H; h++) begin
                @(negedge clk);
                obs[h]  = gfx;
                expv[h] = active ? exp_pix(cx, cy, cd, ca, v, h) : 1'b0;
                if (fs_seen) begin
                    fs_seen = 1'b0;
                    check($sformatf("fs_gfx v%0d h%0d", v, h), int'(gfx), 0);
                    check($sformatf("fs_busy v%0d h%0d", v, h), int'(busy), 1);
                    check($sformatf("fs_row v%0d h%0d", v, h), int'(rom_yofs), 0);
                    check($sformatf("fs_dir v%0d h%0d", v, h), int'(rom_dir), cd);
                    check($sformatf("fs_anim v%0d h%0d", v, h), int'(rom_anim), ca);
                end
                if (active && v >= cy && v <= cy + 15) begin
                    if (h == 0) begin
                        check($sformatf("fetch_row v%0d", v), int'(rom_yofs), v - cy);
                        check($sformatf("fetch_col v%0d", v), int'(rom_xofs), H - 1 - LS_H);
                        check($sformatf("fetch_dir v%0d", v), int'(rom_dir), cd);
                        check($sformatf("fetch_anim v%0d", v), int'(rom_anim), ca);
                        check($sformatf("fetch_busy v%0d", v), int'(busy), 1);
                    end else if (h == 60) begin
                        check($sformatf("xofs_nofetch v%0d", v), int'(rom_xofs), 0);
                    end
                end
                if (v == V - 1 && h == 0)
                    check("end_busy", int'(busy), 0);

                hpos        = 9'(h);
                vpos        = 9'(v);
                line_start  = (h == LS_H);
                frame_start = do_fs && v == 0 && h == 0;
                sprite_x    = 9'($urandom);
                sprite_y    = 9'($urandom);
                direction   = 2'($urandom);
                anim        = 1'($urandom);
                if (frame_start) begin
                    sprite_x  = 9'(sx);
                    sprite_y  = 9'(sy);
                    direction = 2'(d);
                    anim      = 1'(a);
                    active    = 1'b1;
                    fs_seen   = 1'b1;
                end
                if (mode == 1 && v == iv && h == ih) begin
                    frame_start = 1'b1;
                    line_start  = 1'b1;
                    sprite_x    = 9'(nx);
                    sprite_y    = 9'(ny);
                    direction   = 2'(nd);
                    anim        = 1'(na);
                    cx = nx; cy = ny; cd = nd; ca = na;
                    fs_seen = 1'b1;
                end
                if (mode == 2 && v == iv && h == ih) begin
                    check("pre_reset_busy", int'(busy), 1);
                    #2 reset = 1'b1;
                    #1;
                    check("async_rst_gfx", int'(gfx), 0);
                    check("async_rst_busy", int'(busy), 0);
                    check("async_rst_row", int'(rom_yofs), 0);
                    check("async_rst_dir", int'(rom_dir), 0);
                    check("async_rst_anim", int'(rom_anim), 0);
                    check("async_rst_xofs", int'(rom_xofs), 0);
                    #1 reset = 1'b0;
                    active = 1'b0;
                end
            end
            line_obs[v] = obs;
            check_line($sformatf("line %0d", v), obs, expv);
        end
    endtask

    initial begin
        reset       = 1'b1;
        hpos        = 9'd0;
        vpos        = 9'd0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        sprite_x    = 9'd0;
        sprite_y    = 9'd0;
        direction   = 2'd0;
        anim        = 1'b0;
        for (int i = 0; i < 128; i++) rom_mem[i] = 16'($urandom);
        rom_mem[0] = 16'b0011000000000110;

        repeat (3) @(negedge clk);
        check("reset_gfx", int'(gfx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_dir", int'(rom_dir), 0);
        check("reset_anim", int'(rom_anim), 0);
        check("reset_row", int'(rom_yofs), 0);
        check("reset_xofs", int'(rom_xofs), 0);
        reset = 1'b0;

        // no frame_start yet: raster runs, nothing drawn
        run_frame(0, 0, 0, 0, 1'b0, 5, 0, 0, 0, 0, 0, 0, 0);

        // reference sprite at (100,50); row 0 uses the fixed pattern
        run_frame(100, 50, 0, 0, 1'b1, V, 0, 0, 0, 0, 0, 0, 0);
        pat_line = '0;
        pat_line[103] = 1'b1;
        pat_line[104] = 1'b1;
        pat_line[114] = 1'b1;
        pat_line[115] = 1'b1;
        check_line("pattern_line50", line_obs[50], pat_line);
        check_line("blank_line66", line_obs[66], 160'd0);
        check("line50_first_px", int'(line_obs[50][101]), int'(rom_mem[0][15]));

        // x never reached: rows still advance once per line, then done
        run_frame(500, 30, 1, 1, 1'b1, V, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 2; n++)
            run_frame(int'($urandom_range(111, 10)), int'($urandom_range(53, 1)),
                      int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                      1'b1, V, 0, 0, 0, 0, 0, 0, 0);

        // restart mid-DRAW with a new sprite
        run_frame(40, 10, 1, 0, 1'b1, V, 1, 12, 45,
                  int'($urandom_range(111, 10)), 17,
                  int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));

        // reset pulse mid-DRAW, remainder of frame must stay dark
        run_frame(60, 20, 3, 1, 1'b1, V, 2, 21, 65, 0, 0, 0, 0);

        run_frame(int'($urandom_range(111, 10)), int'($urandom_range(53, 1)),
                  int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                  1'b1, V, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
